// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Tracks predictions issued at fetch in an in-order FIFO and compares each
//   one against the outcome computed at execute. It drives the predictor
//   training strobe, raises a one-cycle mispredict/redirect, flushes
//   wrong-path entries, and keeps saturating branch/mispredict counters.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   push_en           fetch issues a predicted branch this cycle
//   push_taken        predicted direction
//   push_target       predicted taken target
//   push_fallthru     sequential PC of the branch (PC+4)
//   push_ready        FIFO not full; fetch stalls when low
//   res_valid         execute resolves the oldest in-flight branch
//   res_taken         actual direction
//   res_target        actual taken target
//   update_en         one-cycle predictor training strobe
//   real_br_taken     actual direction presented with update_en
//   mispredict        one-cycle flush/redirect strobe
//   redirect_pc       correct fetch PC, valid with mispredict
//   resolve_err       sticky: resolve seen with no prediction in flight
//   br_count          resolved branches (saturating)
//   mp_count          mispredicted branches (saturating)
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_en,
  input  logic          push_taken,
  input  logic [AW-1:0] push_target,
  input  logic [AW-1:0] push_fallthru,
  output logic          push_ready,
  input  logic          res_valid,
  input  logic          res_taken,
  input  logic [AW-1:0] res_target,
  output logic          update_en,
  output logic          real_br_taken,
  output logic          mispredict,
  output logic [AW-1:0] redirect_pc,
  output logic          resolve_err,
  output logic [CW-1:0] br_count,
  output logic [CW-1:0] mp_count
);

  localparam int PW = $clog2(DEPTH);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // FIFO storage (data only, never reset) and control state
  logic          mem_taken    [DEPTH];
  logic [AW-1:0] mem_target   [DEPTH];
  logic [AW-1:0] mem_fallthru [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;

  logic          empty, full, do_res, wrong, flush, push_ok;
  logic          head_taken;
  logic [AW-1:0] head_target, head_fallthru;

  logic          update_en_p1, real_br_taken_p1, mispredict_p1, resolve_err_p1;
  logic [AW-1:0] redirect_pc_p1;
  logic [CW-1:0] br_count_p1, mp_count_p1;

  // Stage p0: compare oldest entry against the execute outcome
  always_comb begin
    empty         = (count == '0);
    full          = (count == (PW+1)'(DEPTH));
    head_taken    = mem_taken[rd_ptr];
    head_target   = mem_target[rd_ptr];
    head_fallthru = mem_fallthru[rd_ptr];
    do_res        = res_valid & ~empty;
    wrong         = (head_taken != res_taken) |
                    (head_taken & res_taken & (head_target != res_target));
    flush         = do_res & wrong;
    // A correct pop frees a slot this same cycle, so a push into a full
    // FIFO is accepted then; a flush drops the wrong-path push.
    push_ok       = push_en & ~flush & (~full | do_res);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_taken[wr_ptr]    <= push_taken;
      mem_target[wr_ptr]   <= push_target;
      mem_fallthru[wr_ptr] <= push_fallthru;
    end
  end

  // Stage p1: registered resolution results, pointers and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      update_en_p1     <= 1'b0;
      real_br_taken_p1 <= 1'b0;
      mispredict_p1    <= 1'b0;
      resolve_err_p1   <= 1'b0;
      redirect_pc_p1   <= '0;
      br_count_p1      <= '0;
      mp_count_p1      <= '0;
    end else begin
      update_en_p1  <= do_res;
      mispredict_p1 <= flush;
      if (res_valid && empty) resolve_err_p1 <= 1'b1;
      if (do_res) begin
        real_br_taken_p1 <= res_taken;
        br_count_p1      <= sat_inc(br_count_p1);
      end
      if (flush) begin
        redirect_pc_p1 <= res_taken ? res_target : head_fallthru;
        mp_count_p1    <= sat_inc(mp_count_p1);
        rd_ptr         <= wr_ptr;
        count          <= '0;
      end else begin
        if (do_res)  rd_ptr <= rd_ptr + PW'(1);
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (push_ok && !do_res)      count <= count + (PW+1)'(1);
        else if (!push_ok && do_res) count <= count - (PW+1)'(1);
      end
    end
  end

  assign push_ready    = ~full;
  assign update_en     = update_en_p1;
  assign real_br_taken = real_br_taken_p1;
  assign mispredict    = mispredict_p1;
  assign redirect_pc   = redirect_pc_p1;
  assign resolve_err   = resolve_err_p1;
  assign br_count      = br_count_p1;
  assign mp_count      = mp_count_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_en, push_taken, res_valid, res_taken;
  logic [AW-1:0] push_target, push_fallthru, res_target;

  logic          push_ready, update_en, real_br_taken, mispredict, resolve_err;
  logic [AW-1:0] redirect_pc;
  logic [15:0]   br_count, mp_count;

  logic          s_push_ready, s_update_en, s_real_br_taken, s_mispredict, s_resolve_err;
  logic [AW-1:0] s_redirect_pc;
  logic [3:0]    s_br_count, s_mp_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_en(push_en), .push_taken(push_taken), .push_target(push_target),
    .push_fallthru(push_fallthru), .push_ready(push_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .update_en(update_en), .real_br_taken(real_br_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .resolve_err(resolve_err),
    .br_count(br_count), .mp_count(mp_count)
  );

  // Narrow-counter instance on the same stimulus, for saturation
  branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .push_en(push_en), .push_taken(push_taken), .push_target(push_target),
    .push_fallthru(push_fallthru), .push_ready(s_push_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .update_en(s_update_en), .real_br_taken(s_real_br_taken), .mispredict(s_mispredict),
    .redirect_pc(s_redirect_pc), .resolve_err(s_resolve_err),
    .br_count(s_br_count), .mp_count(s_mp_count)
  );

  typedef struct packed {
    logic          taken;
    logic [AW-1:0] target;
    logic [AW-1:0] fallthru;
  } ent_t;

  // Reference model: in-order queue of predictions plus plain totals
  ent_t          q[$];
  logic          m_upd, m_rt, m_mp, m_err;
  logic [AW-1:0] m_redir;
  int            m_br, m_mpc;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_outputs();
    chk("update_en",     64'(update_en),     64'(m_upd));
    chk("mispredict",    64'(mispredict),    64'(m_mp));
    chk("real_br_taken", 64'(real_br_taken), 64'(m_rt));
    chk("redirect_pc",   64'(redirect_pc),   64'(m_redir));
    chk("resolve_err",   64'(resolve_err),   64'(m_err));
    chk("br_count",      64'(br_count),      64'(sat(m_br, 65535)));
    chk("mp_count",      64'(mp_count),      64'(sat(m_mpc, 65535)));
    chk("occupancy",     64'(dut.count),     64'(q.size()));
    chk("br_count_cw4",  64'(s_br_count),    64'(sat(m_br, 15)));
    chk("mp_count_cw4",  64'(s_mp_count),    64'(sat(m_mpc, 15)));
    chk("mispredict_cw4", 64'(s_mispredict), 64'(m_mp));
  endtask

  task automatic model_reset();
    q.delete();
    m_upd = 0; m_rt = 0; m_mp = 0; m_err = 0; m_redir = '0; m_br = 0; m_mpc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push_en = 0; push_taken = 0; push_target = '0; push_fallthru = '0;
    res_valid = 0; res_taken = 0; res_target = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    chk("push_ready_after_reset", 64'(push_ready), 64'(1));
  endtask

  task automatic step(input logic pe, input logic pt, input logic [AW-1:0] ptg,
                      input logic [AW-1:0] pft, input logic rv, input logic rt,
                      input logic [AW-1:0] rtg);
    ent_t e, n;
    logic w;
    push_en = pe; push_taken = pt; push_target = ptg; push_fallthru = pft;
    res_valid = rv; res_taken = rt; res_target = rtg;
    chk("push_ready",     64'(push_ready),   64'(q.size() != DEPTH));
    chk("push_ready_cw4", 64'(s_push_ready), 64'(q.size() != DEPTH));
    n = '{taken: pt, target: ptg, fallthru: pft};
    m_upd = 0; m_mp = 0;
    if (rv && q.size() == 0) begin
      m_err = 1;
      if (pe) q.push_back(n);
    end else if (rv) begin
      e = q[0];
      w = (e.taken != rt) || (e.taken && rt && e.target != rtg);
      m_upd = 1; m_rt = rt; m_mp = w; m_br++;
      if (w) begin
        m_mpc++;
        m_redir = rt ? rtg : e.fallthru;
        q.delete();
      end else begin
        void'(q.pop_front());
        if (pe) q.push_back(n);
      end
    end else if (pe && q.size() < DEPTH) begin
      q.push_back(n);
    end
    @(posedge clk); #1;
    push_en = 0; res_valid = 0;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0);
  endtask

  initial begin
    logic [AW-1:0] tg [3];
    tg[0] = 32'h100; tg[1] = 32'h104; tg[2] = 32'h200;
    rst_n = 1'b0;
    push_en = 0; push_taken = 0; push_target = '0; push_fallthru = '0;
    res_valid = 0; res_taken = 0; res_target = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Correct taken prediction
    step(1, 1, 32'h100, 32'h44, 0, 0, '0);
    step(0, 0, '0, '0, 1, 1, 32'h100);
    chk("t1_update_en", 64'(update_en), 64'(1));
    chk("t1_br_count",  64'(br_count),  64'(1));

    // Direction mispredicts
    step(1, 0, 32'h0, 32'h48, 0, 0, '0);
    step(0, 0, '0, '0, 1, 1, 32'h200);
    chk("t2_redirect_taken", 64'(redirect_pc), 64'h200);
    step(1, 1, 32'h300, 32'h80, 0, 0, '0);
    step(0, 0, '0, '0, 1, 0, '0);
    chk("t2_redirect_fallthru", 64'(redirect_pc), 64'h80);
    chk("t2_mp_count", 64'(mp_count), 64'(2));

    // Target mismatch with younger entries flushed, then resolve on empty
    step(1, 1, 32'h100, 32'h10, 0, 0, '0);
    step(1, 0, 32'h0,   32'h20, 0, 0, '0);
    step(1, 1, 32'h500, 32'h30, 0, 0, '0);
    step(0, 0, '0, '0, 1, 1, 32'h104);
    chk("t3_redirect", 64'(redirect_pc), 64'h104);
    chk("t3_count",    64'(dut.count),   64'(0));
    step(0, 0, '0, '0, 1, 1, 32'h104);
    chk("t3_resolve_err", 64'(resolve_err), 64'(1));
    do_reset();

    // Fill, overfill, simultaneous correct resolve+push when full, drain
    for (int i = 0; i < 5; i++) step(1, 1, 32'h1000 + 32'(i * 16), 32'h4 * 32'(i), 0, 0, '0);
    chk("t4_full", 64'(push_ready), 64'(0));
    step(1, 0, 32'h0, 32'h900, 1, 1, 32'h1000);
    chk("t4_count_full", 64'(dut.count), 64'(4));
    step(0, 0, '0, '0, 1, 1, 32'h1010);
    step(0, 0, '0, '0, 1, 1, 32'h1020);
    step(0, 0, '0, '0, 1, 1, 32'h1030);
    step(0, 0, '0, '0, 1, 0, '0);
    chk("t4_drain_ok", 64'(mp_count), 64'(0));

    // Push + mispredicting resolve with 2 held: push dropped
    step(1, 0, 32'h0, 32'h60, 0, 0, '0);
    step(1, 0, 32'h0, 32'h64, 0, 0, '0);
    step(1, 1, 32'h700, 32'h68, 1, 1, 32'h800);
    step(0, 0, '0, '0, 1, 0, '0);
    chk("t5_err", 64'(resolve_err), 64'(1));

    // Reset mid-operation with entries held
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'h40, 32'h4, 0, 0, '0);
      step(0, 0, '0, '0, 1, 1, 32'h40);
    end
    for (int i = 0; i < 3; i++) step(1, 0, '0, 32'h8, 0, 0, '0);
    do_reset();

    // Saturation of the 4-bit counters
    step(1, 1, 32'h200, 32'h4, 0, 0, '0);
    for (int i = 0; i < 20; i++) step(1, 1, 32'h200, 32'h4, 1, 1, 32'h200);
    chk("sat_br_cw4", 64'(s_br_count), 64'(15));
    for (int i = 0; i < 20; i++) begin
      step(1, 0, '0, 32'h4, 0, 0, '0);
      step(0, 0, '0, '0, 1, 1, 32'h200);
    end
    chk("sat_mp_cw4", 64'(s_mp_count), 64'(15));

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                tg[$urandom_range(0, 2)], 32'($urandom_range(0, 255)) << 2,
                $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)),
                tg[$urandom_range(0, 2)]);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
